afp_mul_arbiter: RTL and testbench

- Shares one combinational 4-bit AFP multiplier core (afp_multiplier: x, y in; result out) between NREQ requesters.
- Arbitration is round-robin.
- A 2-stage pipeline sits around the core: S1 is the operand register driving the core; S2 is the result/response register.
- Responses carry the requester ID, go out on one shared response channel, and honour backpressure.

---
 rtl/afp_mul_arbiter.sv | 118 +++++++++++
 tb/tb_afp_mul_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afp_mul_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit AFP multiplier core
// between NREQ requesters. S1 holds the granted operands and drives the core;
// S2 captures the product and presents it on the shared response channel.
module afp_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_x,
  input  logic [4*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic [3:0]        core_x,
  output logic [3:0]        core_y,
  input  logic [3:0]        core_result,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_result,
  input  logic              rsp_ready,
  output logic              busy
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           s1_valid_q;
  logic [3:0]     s1_x_q, s1_y_q;
  logic [IDW-1:0] s1_id_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [3:0]     rsp_result_q;

  logic           s2_adv, s1_adv;
  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic           accept;

  assign s2_adv = !rsp_valid_q || rsp_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  // Grant: first valid requester scanning from ptr upward, wrapping mod NREQ
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  assign accept = gnt_found && s1_adv;

  // Only the granted requester sees ready, and only when S1 can take it
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = accept && (gnt_id == IDW'(i));
  end

  // Pointer moves past the winner on accept, otherwise holds
  always_comb begin
    ptr_d = ptr_q;
    if (accept)
      ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // S1: operand register; empties when it advances without a new accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_id_q    <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_x_q     <= req_x[4*gnt_id +: 4];
      s1_y_q     <= req_y[4*gnt_id +: 4];
      s1_id_q    <= gnt_id;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Core inputs are forced to zero while S1 is empty
  assign core_x = s1_valid_q ? s1_x_q : 4'h0;
  assign core_y = s1_valid_q ? s1_y_q : 4'h0;

  // S2: response register; holds stable under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else if (s2_adv) begin
      rsp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_id_q     <= s1_id_q;
        rsp_result_q <= core_result;
      end
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = s1_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_afp_mul_arbiter.sv
// Bench for afp_mul_arbiter: XOR stands in for the multiplier core; a
// scoreboard queue records every accept and is checked against responses.
module tb_afp_mul_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_x, req_y;
  logic [NREQ-1:0]   req_ready;
  logic [3:0]        core_x, core_y, core_result;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_result;
  logic              rsp_ready;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;

  typedef struct { logic [IDW-1:0] id; logic [3:0] res; } sb_t;
  sb_t sb[$];

  afp_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
    .req_y(req_y), .req_ready(req_ready), .core_x(core_x), .core_y(core_y),
    .core_result(core_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_ready(rsp_ready), .busy(busy)
  );

  assign core_result = core_x ^ core_y;

  always #5 clk = ~clk;

  // Monitor at negedge: push on accept, pop/compare on response handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      checks++;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL onehot: req_ready=%b must be one-hot or zero", req_ready);
      end
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) begin
          sb_t e;
          e.id  = IDW'(i);
          e.res = req_x[4*i +: 4] ^ req_y[4*i +: 4];
          sb.push_back(e);
        end
      if (rsp_valid && rsp_ready) begin
        sb_t e;
        checks++;
        rsp_cnt++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: id=%0d res=%h with no pending accept", rsp_id, rsp_result);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_result !== e.res) begin
            errors++;
            $display("FAIL sb_rsp: got id=%0d res=%h expected id=%0d res=%h",
                     rsp_id, rsp_result, e.id, e.res);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0; #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 ||
        core_x !== 4'h0 || core_y !== 4'h0 || rsp_id !== '0 ||
        rsp_result !== 4'h0 || dut.ptr_q !== '0) begin
      errors++;
      $display("FAIL reset: rv=%b busy=%b rdy=%b cx=%h cy=%h id=%0d res=%h ptr=%0d expected all zero",
               rsp_valid, busy, req_ready, core_x, core_y, rsp_id, rsp_result, dut.ptr_q);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_x[3:0] = 4'h2; req_y[3:0] = 4'h3;
    #1 checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: req_ready=%b expected 0001", req_ready);
    end
    tick(); req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || core_x !== 4'h2 || core_y !== 4'h3) begin
      errors++;
      $display("FAIL single_s1: rv=%b busy=%b cx=%h cy=%h expected 0 1 2 3", rsp_valid, busy, core_x, core_y);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 4'h1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp: rv=%b id=%0d res=%h busy=%b expected 1 0 1 1",
               rsp_valid, rsp_id, rsp_result, busy);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: rv=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_x[4*i +: 4] = 4'(i); req_y[4*i +: 4] = 4'hF;
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      logic [NREQ-1:0] exp_rdy;
      exp_rdy = '0; exp_rdy[k % NREQ] = 1'b1;
      #1 checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL contention_grant%0d: req_ready=%b expected %b", k, req_ready, exp_rdy);
      end
      if (k >= 2) begin
        checks++;
        if (rsp_id !== 2'((k-2) % NREQ) || rsp_result !== (4'hF ^ 4'((k-2) % NREQ))) begin
          errors++;
          $display("FAIL contention_rsp%0d: id=%0d res=%h expected id=%0d res=%h",
                   k, rsp_id, rsp_result, (k-2) % NREQ, 4'hF ^ 4'((k-2) % NREQ));
        end
      end
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    int base;
    logic [3:0] held;
    do_reset();
    base = rsp_cnt;
    rsp_ready = 1'b0;
    req_valid = 4'b0100; req_x[11:8] = 4'h5; req_y[11:8] = 4'h1;
    tick();
    req_x[11:8] = 4'h6; req_y[11:8] = 4'h2;
    #1 checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_second_ready: req_ready=%b expected 0100", req_ready);
    end
    tick();
    req_x[11:8] = 4'h7; req_y[11:8] = 4'h4;
    held = rsp_result;
    for (int c = 0; c < 3; c++) begin
      #1 checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd2 ||
          rsp_result !== 4'h4 || held !== 4'h4) begin
        errors++;
        $display("FAIL bp_hold%0d: rdy=%b rv=%b id=%0d res=%h expected 0000 1 2 4", c,
                 req_ready, rsp_valid, rsp_id, rsp_result);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1 checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_release: req_ready=%b expected 0100", req_ready);
    end
    tick();
    req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (rsp_cnt - base !== 3) begin
      errors++; $display("FAIL bp_count: responses=%0d expected 3", rsp_cnt - base);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    req_valid = 4'b0010; req_x[7:4] = 4'h9; req_y[7:4] = 4'h9;
    tick();
    req_valid = '0;
    tick(); tick();
    checks++;
    if (dut.ptr_q !== 2'd2) begin
      errors++; $display("FAIL fair_ptr_pre: ptr=%0d expected 2", dut.ptr_q);
    end
    req_valid = 4'b1010; req_x[15:12] = 4'hA; req_y[15:12] = 4'h3; req_x[7:4] = 4'h1; req_y[7:4] = 4'h8;
    #1 checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL fair_first: req_ready=%b expected 1000", req_ready);
    end
    tick();
    req_valid = 4'b0010;
    #1 checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL fair_second: req_ready=%b expected 0010", req_ready);
    end
    tick();
    req_valid = '0;
    tick(); tick();
    checks++;
    if (dut.ptr_q !== 2'd2) begin
      errors++; $display("FAIL fair_ptr_end: ptr=%0d expected 2", dut.ptr_q);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 4'b0011; req_x[7:0] = 8'h21; req_y[7:0] = 8'h43;
    rsp_ready = 1'b0;
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_setup: rv=%b busy=%b expected 1 1", rsp_valid, busy);
    end
    #2 rst_n = 1'b0;
    #1 checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || dut.ptr_q !== '0) begin
      errors++;
      $display("FAIL mid_async: rv=%b busy=%b ptr=%0d expected 0 0 0", rsp_valid, busy, dut.ptr_q);
    end
    rsp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1 checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_stale: rv=%b expected 0 after release", rsp_valid);
    end
    tick();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_stale2: rv=%b expected 0", rsp_valid);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_idle();
    logic [IDW-1:0] p0;
    req_valid = '0;
    p0 = dut.ptr_q;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (core_x !== 4'h0 || core_y !== 4'h0 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle%0d: cx=%h cy=%h rv=%b expected 0 0 0", c, core_x, core_y, rsp_valid);
      end
    end
    checks++;
    if (dut.ptr_q !== p0) begin
      errors++; $display("FAIL idle_ptr: ptr=%0d expected %0d", dut.ptr_q, p0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_fairness();
    test_reset_midflight();
    test_idle();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d responses never arrived", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
